// File: rtl/text_buffer.sv
// Character screen store: byte-stream writer with cursor/scroll/clear control
// and a 1-cycle registered glyph-rate read port for the character generator.
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       rd_en,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_char,
  output logic       rd_cursor,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0] LAST_CNT_COL = AW'(COLS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SCROLL} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q;
  logic [4:0]      top_q;
  logic [4:0]      scr_row_q;
  logic [7:0]      mem [CELLS];

  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;
  logic            acc, is_ctrl, printable, lf_now;
  logic [AW-1:0]   cur_addr, rd_addr;
  logic            rd_ok;

  // Logical row is rotated by the scroll offset; the wrap keeps phys < ROWS.
  function automatic logic [AW-1:0] phys_addr(input logic [4:0] row,
                                              input logic [6:0] col,
                                              input logic [4:0] top);
    logic [5:0] p;
    p = {1'b0, row} + {1'b0, top};
    if (p >= 6'(ROWS)) p = p - 6'(ROWS);
    return AW'(32'(p) * 32'(COLS) + 32'(col));
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign cur_addr = phys_addr(cursor_row, cursor_col, top_q);
  assign rd_ok    = ({1'b0, rd_col} < 8'(COLS)) && ({1'b0, rd_row} < 6'(ROWS));
  assign rd_addr  = rd_ok ? phys_addr(rd_row, rd_col, top_q) : '0;
  assign is_ctrl  = in_char inside {8'h0D, 8'h0A, 8'h08, 8'h0C};

  always_comb begin
    state_d   = state_q;
    we        = 1'b0;
    waddr     = cnt_q;
    wdata     = 8'h20;
    acc       = 1'b0;
    printable = 1'b0;
    lf_now    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        we = 1'b1;
        if (cnt_q == LAST_CELL) state_d = S_IDLE;
      end
      S_SCROLL: begin
        we    = 1'b1;
        waddr = AW'(32'(scr_row_q) * 32'(COLS) + 32'(cnt_q));
        if (cnt_q == LAST_CNT_COL) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (in_valid) begin
          acc       = 1'b1;
          printable = !is_ctrl;
          // Printable in the last column wraps immediately, acting as LF too.
          lf_now    = (in_char == 8'h0A) || (!is_ctrl && cursor_col == LAST_COL);
          if (in_char == 8'h0C) state_d = S_CLEAR;
          if (!is_ctrl) begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = in_char;
          end
          if (lf_now && cursor_row == LAST_ROW) state_d = S_SCROLL;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      top_q      <= '0;
      scr_row_q  <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != state_d)      cnt_q <= '0;
      else if (state_q != S_IDLE)  cnt_q <= cnt_q + 1'b1;

      if (state_q == S_CLEAR && state_d == S_IDLE) begin
        cursor_col <= '0;
        cursor_row <= '0;
        top_q      <= '0;
      end

      if (acc) begin
        if (in_char == 8'h0D) cursor_col <= '0;
        if (in_char == 8'h08 && cursor_col != '0) cursor_col <= cursor_col - 1'b1;
        if (printable) cursor_col <= (cursor_col == LAST_COL) ? 7'd0 : cursor_col + 1'b1;
        if (lf_now) begin
          if (cursor_row != LAST_ROW) cursor_row <= cursor_row + 1'b1;
          else begin
            // Old top physical row becomes the new bottom line and is blanked.
            scr_row_q <= top_q;
            top_q     <= (top_q == LAST_ROW) ? 5'd0 : top_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples mem before this cycle's write lands, so collisions see old data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_char   <= 8'h20;
      rd_cursor <= 1'b0;
    end else if (rd_en) begin
      rd_char   <= rd_ok ? mem[rd_addr] : 8'h20;
      rd_cursor <= rd_ok && (rd_col == cursor_col) && (rd_row == cursor_row);
    end
  end

endmodule
